// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU controller slice.
//   state_t        - controller FSM states (S_ILLEGAL only when
//                    CPU_CTRL_ILLEGAL_EN is defined)
//   instr_class_t  - decoded instruction class produced by instr_decoder
//   OPC_* / OP_*   - opcode (IR[15:13]) and op (IR[12:11]) encodings
//   VSEL_*         - register-file write-back source select
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WR_REG,
    S_WR_IMM
`ifdef CPU_CTRL_ILLEGAL_EN
    , S_ILLEGAL
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_MOV_IMM,
    CLS_MOV_REG,
    CLS_ADD,
    CLS_CMP,
    CLS_AND,
    CLS_MVN
  } instr_class_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/cpu_controller_instr_decoder.sv
// instr_decoder: purely combinational split of the instruction register.
//   ir      in   16      instruction register contents
//   rn      out  3       IR[10:8]
//   rd      out  3       IR[7:5]
//   rm      out  3       IR[2:0]
//   shift   out  2       IR[4:3]
//   alu_op  out  2       IR[12:11]
//   sximm5  out  DATA_W  sign-extended IR[4:0]
//   sximm8  out  DATA_W  sign-extended IR[7:0]
//   cls     out  3       instruction class (CLS_NONE when not decodable)
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [15:0]       ir,
  output logic [2:0]        rn,
  output logic [2:0]        rd,
  output logic [2:0]        rm,
  output logic [1:0]        shift,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8,
  output instr_class_t      cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign alu_op = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = {{(DATA_W-5){ir[4]}}, ir[4:0]};
  assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

  always_comb begin
    cls = CLS_NONE;
    if (opcode == OPC_MOV) begin
      if (alu_op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (alu_op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (alu_op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register plus Moore FSM that walks the
// datapath through one instruction at a time.
//   clk, reset            clock, synchronous active-high reset
//   in, load, s           instruction word, IR load strobe, start strobe
//                         (load and s only take effect in S_WAIT)
//   w                     1 while idle in S_WAIT
//   readnum/writenum      register file indices
//   vsel, write           write-back source select and write enable
//   loada/b/c, loads      datapath register loads
//   asel, bsel            ALU operand overrides
//   shift, ALUop          IR[4:3], IR[12:11]
//   sximm5, sximm8        sign-extended immediates
//   illegal               present only when CPU_CTRL_ILLEGAL_EN is defined;
//                         sticky flag for an undecodable instruction
// Without CPU_CTRL_ILLEGAL_EN an undecodable instruction behaves as a NOP.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter logic [15:0] RESET_IR = 16'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       in,
  input  logic              load,
  input  logic              s,
  output logic              w,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic [1:0]        vsel,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              write,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [DATA_W-1:0] sximm5,
  output logic [DATA_W-1:0] sximm8
`ifdef CPU_CTRL_ILLEGAL_EN
  , output logic            illegal
`endif
);

  state_t       state_reg, state_next;
  logic [15:0]  ir_reg;
  logic [2:0]   rn, rd, rm;
  instr_class_t cls;

  instr_decoder #(.DATA_W(DATA_W)) u_dec (
    .ir     (ir_reg),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .shift  (shift),
    .alu_op (ALUop),
    .sximm5 (sximm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // IR only accepts a new word while idle, so it stays stable for the whole
  // instruction. A load together with s executes the freshly latched word,
  // since DECODE sees the register after this same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_WAIT;
      ir_reg    <= RESET_IR;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_WAIT && load)
        ir_reg <= in;
    end
  end

  always_comb begin
    state_next = state_reg;
    w          = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    vsel       = VSEL_C;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    write      = 1'b0;
    asel       = 1'b0;
    case (state_reg)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (cls)
          CLS_MOV_IMM:               state_next = S_WR_IMM;
          CLS_ADD, CLS_CMP, CLS_AND: state_next = S_GET_A;
          CLS_MOV_REG, CLS_MVN:      state_next = S_GET_B;
`ifdef CPU_CTRL_ILLEGAL_EN
          default:                   state_next = S_ILLEGAL;
`else
          default:                   state_next = S_WAIT;
`endif
        endcase
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        state_next = S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        state_next = S_ALU;
      end
      S_ALU: begin
        // MOV Rd,Rm is computed as 0 + shifted Rm, hence the zeroed A input.
        asel = (cls == CLS_MOV_REG);
        if (cls == CLS_CMP) begin
          loads      = 1'b1;
          state_next = S_WAIT;
        end else begin
          loadc      = 1'b1;
          state_next = S_WR_REG;
        end
      end
      S_WR_REG: begin
        write      = 1'b1;
        writenum   = rd;
        vsel       = VSEL_C;
        state_next = S_WAIT;
      end
      S_WR_IMM: begin
        write      = 1'b1;
        writenum   = rn;
        vsel       = VSEL_IMM;
        state_next = S_WAIT;
      end
`ifdef CPU_CTRL_ILLEGAL_EN
      S_ILLEGAL: state_next = S_ILLEGAL;
`endif
      default: state_next = S_WAIT;
    endcase
  end

  assign bsel = 1'b0;

`ifdef CPU_CTRL_ILLEGAL_EN
  assign illegal = (state_reg == S_ILLEGAL);
`endif

endmodule
